// File: rtl/song_pkg.sv
// Constants and state type shared by the song recorder and the player.
// Defines the song memory window, end-of-song marker, rest code and slot length.
package song_pkg;
    localparam int          CYCLES_PER_NOTE = 25000000;
    localparam int          START_ADDRESS   = 753;
    localparam int          MAX_ADDRESS     = 997;
    localparam logic [7:0]  END_SIGNAL      = 8'h7C;
    localparam logic [6:0]  REST_NOTE       = 7'h7F;
    localparam int          CNT_W           = 25;
    localparam int          ADDR_W          = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } play_state_t;
endpackage

// File: rtl/play_song_slot_timer.sv
// Note-slot counter: terminal count on the last slot cycle, prefetch strobe LATENCY cycles in.
// No backpressure; clear holds the count at zero, otherwise it wraps on terminal count.
module slot_timer #(
    parameter int CYCLES  = 25000000,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tc,
    output logic prefetch
);
    import song_pkg::*;

    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;

    assign tc       = (counter_q == CNT_W'(CYCLES - 1));
    assign prefetch = (counter_q == CNT_W'(LATENCY));

    always_comb begin
        counter_d = counter_q + 1'b1;
        if (clear || tc) begin
            counter_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end
endmodule

// File: rtl/play_song.sv
// Song player: reads bytes from BRAM and emits one note per slot; first note READ_LATENCY+1 cycles after start.
// No backpressure; the next byte is prefetched inside each slot so slots are exactly CYCLES_PER_NOTE long.
module play_song #(
    parameter int CYCLES_PER_NOTE = song_pkg::CYCLES_PER_NOTE,
    parameter int READ_LATENCY    = 2
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] bram_data,
    output logic [9:0] bram_addr,
    output logic [6:0] note_out,
    output logic       note_valid,
    output logic       playing,
    output logic       done
);
    import song_pkg::*;

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDRESS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MAX_ADDRESS - 1);

    play_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        note_q, note_d;
    logic              note_valid_q, note_valid_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [7:0]        next_byte_q, next_byte_d;
    logic              last_q, last_d;
    logic              timer_clr, timer_tc, timer_pf;
    logic              emit;
    logic [7:0]        emit_byte;

    // Bytes with the top bit set are corrupt and play as silence.
    function automatic logic [6:0] decode(input logic [7:0] b);
        return b[7] ? REST_NOTE : b[6:0];
    endfunction

    slot_timer #(
        .CYCLES  (CYCLES_PER_NOTE),
        .LATENCY (READ_LATENCY)
    ) u_slot_timer (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .clear    (timer_clr),
        .tc       (timer_tc),
        .prefetch (timer_pf)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        note_d       = note_q;
        note_valid_d = 1'b0;
        playing_d    = playing_q;
        done_d       = 1'b0;
        lat_cnt_d    = lat_cnt_q;
        next_byte_d  = next_byte_q;
        last_d       = last_q;
        timer_clr    = 1'b1;
        emit         = 1'b0;
        emit_byte    = 8'h00;

        if (stop && state_q != IDLE) begin
            state_d   = IDLE;
            note_d    = REST_NOTE;
            playing_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        addr_d    = START_A;
                        lat_cnt_d = '0;
                        last_d    = 1'b0;
                        playing_d = 1'b1;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    if (lat_cnt_q == 3'(READ_LATENCY)) begin
                        if (bram_data == END_SIGNAL) begin
                            done_d    = 1'b1;
                            playing_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            emit      = 1'b1;
                            emit_byte = bram_data;
                            state_d   = PLAY;
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end
                PLAY: begin
                    timer_clr = 1'b0;
                    if (timer_pf) begin
                        next_byte_d = bram_data;
                    end
                    if (timer_tc) begin
                        if (next_byte_q == END_SIGNAL || last_q) begin
                            note_d    = REST_NOTE;
                            done_d    = 1'b1;
                            playing_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            emit      = 1'b1;
                            emit_byte = next_byte_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The last usable address is played but never stepped past.
        if (emit) begin
            note_d       = decode(emit_byte);
            note_valid_d = 1'b1;
            if (addr_q == LAST_A) begin
                last_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= START_A;
            note_q       <= REST_NOTE;
            note_valid_q <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
            lat_cnt_q    <= '0;
            next_byte_q  <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
            lat_cnt_q    <= lat_cnt_d;
            next_byte_q  <= next_byte_d;
            last_q       <= last_d;
        end
    end

    assign bram_addr  = addr_q;
    assign note_out   = note_q;
    assign note_valid = note_valid_q;
    assign playing    = playing_q;
    assign done       = done_q;
endmodule

// File: tb/tb_play_song.sv
// Scoreboard bench for play_song with a short slot and a two-cycle BRAM model.
module tb_play_song;
    localparam int CPN   = 8;
    localparam int RL    = 2;
    localparam int START = 753;
    localparam int MAXA  = 997;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] bram_data;
    logic [9:0] bram_addr;
    logic [6:0] note_out;
    logic       note_valid;
    logic       playing;
    logic       done;

    always #5 clk = ~clk;

    play_song #(
        .CYCLES_PER_NOTE (CPN),
        .READ_LATENCY    (RL)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .bram_data  (bram_data),
        .bram_addr  (bram_addr),
        .note_out   (note_out),
        .note_valid (note_valid),
        .playing    (playing),
        .done       (done)
    );

    logic [7:0] mem [0:1023];
    logic [7:0] pipe [RL];

    always @(posedge clk) begin
        pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_data = pipe[RL-1];

    typedef struct {
        bit         is_done;
        logic [6:0] note;
        int         offs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   addr_oob = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_event(input bit d, input logic [6:0] n);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s got note=%h at offset %0d, nothing expected",
                     d ? "done" : "note", n, cyc - start_cyc);
        end else begin
            e = q.pop_front();
            if (e.is_done != d || (!d && e.note != n) || (cyc - start_cyc) != e.offs) begin
                errors++;
                $display("FAIL event got done=%0d note=%h offset=%0d, want done=%0d note=%h offset=%0d",
                         d, n, cyc - start_cyc, e.is_done, e.note, e.offs);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bram_addr < 10'(START) || bram_addr >= 10'(MAXA)) addr_oob = 1'b1;
            if (note_valid) check_event(1'b0, note_out);
            if (done) check_event(1'b1, 7'h00);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_note(input logic [6:0] n, input int offs);
        exp_t e;
        e.is_done = 1'b0; e.note = n; e.offs = offs;
        q.push_back(e);
    endtask

    task automatic push_done(input int offs);
        exp_t e;
        e.is_done = 1'b1; e.note = 7'h00; e.offs = offs;
        q.push_back(e);
    endtask

    task automatic do_start(input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        start_cyc = cyc + 1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d events pending want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 8'h7C;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear_mem();
        #23;
        chk("rst_addr",    32'(bram_addr),  32'(START));
        chk("rst_note",    32'(note_out),   32'h7F);
        chk("rst_valid",   32'(note_valid), 32'h0);
        chk("rst_playing", 32'(playing),    32'h0);
        chk("rst_done",    32'(done),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Two notes then the end marker
        mem[753] = 8'h05; mem[754] = 8'h0A; mem[755] = 8'h7C;
        push_note(7'h05, 3); push_note(7'h0A, 3 + CPN); push_done(3 + 2 * CPN);
        do_start(1'b0);
        tick(4);
        chk("t1_playing_mid", 32'(playing), 32'h1);
        drain("t1", 60);
        tick(3);
        chk("t1_note_end",    32'(note_out), 32'h7F);
        chk("t1_playing_end", 32'(playing),  32'h0);

        // Immediate end marker: done only, no note
        clear_mem();
        push_done(RL + 1);
        do_start(1'b0);
        drain("t2", 20);
        tick(3);
        chk("t2_playing", 32'(playing), 32'h0);

        // Rest code passes through, corrupt byte silenced
        clear_mem();
        mem[753] = 8'h03; mem[754] = 8'h7F; mem[755] = 8'h85; mem[756] = 8'h7C;
        push_note(7'h03, 3); push_note(7'h7F, 3 + CPN); push_note(7'h7F, 3 + 2 * CPN);
        push_done(3 + 3 * CPN);
        do_start(1'b0);
        drain("t3", 80);
        tick(3);
        chk("t3_note_end", 32'(note_out), 32'h7F);

        // No end marker: run to the memory limit
        clear_mem();
        for (int a = START; a < MAXA; a++) mem[a] = 8'(a % 100);
        for (int k = 0; k < MAXA - START; k++) push_note(7'(((START + k) % 100)), 3 + CPN * k);
        push_done(3 + CPN * (MAXA - START));
        addr_oob = 1'b0;
        do_start(1'b0);
        drain("t4", 2200);
        tick(3);
        chk("t4_addr_oob", 32'(addr_oob), 32'h0);
        chk("t4_playing",  32'(playing),  32'h0);

        // Stop during the second slot, then replay from the start
        clear_mem();
        mem[753] = 8'h05; mem[754] = 8'h0A; mem[755] = 8'h0B; mem[756] = 8'h7C;
        push_note(7'h05, 3); push_note(7'h0A, 3 + CPN);
        do_start(1'b0);
        tick(13);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t5_note_stop",    32'(note_out), 32'h7F);
        chk("t5_playing_stop", 32'(playing),  32'h0);
        drain("t5a", 5);
        tick(20);
        push_note(7'h05, 3); push_note(7'h0A, 3 + CPN); push_note(7'h0B, 3 + 2 * CPN);
        push_done(3 + 3 * CPN);
        do_start(1'b0);
        drain("t5b", 80);
        tick(3);

        // Asynchronous reset in the middle of a slot
        clear_mem();
        mem[753] = 8'h05; mem[754] = 8'h0A; mem[755] = 8'h0B; mem[756] = 8'h7C;
        push_note(7'h05, 3); push_note(7'h0A, 3 + CPN);
        do_start(1'b0);
        tick(13);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_addr",    32'(bram_addr),  32'(START));
        chk("t6_note",    32'(note_out),   32'h7F);
        chk("t6_valid",   32'(note_valid), 32'h0);
        chk("t6_playing", 32'(playing),    32'h0);
        chk("t6_done",    32'(done),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("t6", 5);
        tick(20);

        // Start and stop together from idle
        do_start(1'b1);
        chk("t7_playing_now", 32'(playing), 32'h0);
        tick(20);
        chk("t7_playing_later", 32'(playing), 32'h0);
        chk("t7_note", 32'(note_out), 32'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
